// File: rtl/lc3_wb_scheduler.sv
// LC3 register-file writeback scheduler: in-order pipeline write queue plus host
// write requester sharing one registered write port, with sr1/sr2 hazard flags.
module lc3_wb_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_enable_writeback,
  input  logic [1:0]               i_W_Control_in,
  input  logic [15:0]              i_aluout,
  input  logic [15:0]              i_memout,
  input  logic [15:0]              i_pcout,
  input  logic [15:0]              i_npc_in,
  input  logic [2:0]               i_dr,
  output logic                     o_wb_ready,
  input  logic                     i_flush,
  input  logic                     i_host_req,
  input  logic [2:0]               i_host_dr,
  input  logic [15:0]              i_host_data,
  output logic                     o_host_gnt,
  input  logic [2:0]               i_sr1,
  input  logic [2:0]               i_sr2,
  output logic                     o_sr1_busy,
  output logic                     o_sr2_busy,
  output logic                     o_rf_we,
  output logic [2:0]               o_rf_waddr,
  output logic [15:0]              o_rf_wdata,
  output logic [$clog2(DEPTH):0]   o_wb_count
);
  localparam int AW = $clog2(DEPTH);

  logic [2:0]    r_q_dr   [DEPTH];
  logic [15:0]   r_q_data [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_rf_we, r_host_gnt, r_last_host;
  logic [2:0]    r_rf_waddr;
  logic [15:0]   r_rf_wdata;

  logic          w_wb_ready, w_push, w_q_cand, w_h_cand, w_gnt_q, w_gnt_h;
  logic [15:0]   w_sel_data;
  logic [AW-1:0] w_off [DEPTH];
  logic [DEPTH-1:0] w_live;
  logic          w_sr1_busy, w_sr2_busy;

  // Data is chosen at accept time so later changes on the buses do not matter.
  always_comb begin
    w_sel_data = i_aluout;
    case (i_W_Control_in)
      2'd1:    w_sel_data = i_memout;
      2'd2:    w_sel_data = i_pcout;
      2'd3:    w_sel_data = i_npc_in;
      default: w_sel_data = i_aluout;
    endcase
  end

  assign w_wb_ready = (r_count < (AW+1)'(DEPTH));
  assign w_push     = i_enable_writeback & w_wb_ready & ~i_flush;
  // A flush hides the queue from arbitration so only the host can issue.
  assign w_q_cand   = (r_count != '0) & ~i_flush;
  assign w_h_cand   = i_host_req & ~r_host_gnt;
  assign w_gnt_q    = w_q_cand & (~w_h_cand | r_last_host);
  assign w_gnt_h    = w_h_cand & ~w_gnt_q;

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_q_dr[r_wptr]   <= i_dr;
      r_q_data[r_wptr] <= w_sel_data;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_wptr <= r_wptr + AW'(1);
      if (w_gnt_q) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_gnt_q);
    end
  end

  // last_grant follows every grant; it only decides ties.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rf_we     <= 1'b0;
      r_host_gnt  <= 1'b0;
      r_last_host <= 1'b1;
      r_rf_waddr  <= '0;
      r_rf_wdata  <= '0;
    end else begin
      r_rf_we    <= w_gnt_q | w_gnt_h;
      r_host_gnt <= w_gnt_h;
      if (w_gnt_q) begin
        r_rf_waddr  <= r_q_dr[r_rptr];
        r_rf_wdata  <= r_q_data[r_rptr];
        r_last_host <= 1'b0;
      end else if (w_gnt_h) begin
        r_rf_waddr  <= i_host_dr;
        r_rf_wdata  <= i_host_data;
        r_last_host <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_off[i]  = AW'(i) - r_rptr;
      w_live[i] = ({1'b0, w_off[i]} < r_count);
    end
  end

  // Hazard covers queued entries plus the write sitting in the output stage.
  always_comb begin
    w_sr1_busy = r_rf_we && (r_rf_waddr == i_sr1);
    w_sr2_busy = r_rf_we && (r_rf_waddr == i_sr2);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_live[i] && (r_q_dr[i] == i_sr1)) w_sr1_busy = 1'b1;
      if (w_live[i] && (r_q_dr[i] == i_sr2)) w_sr2_busy = 1'b1;
    end
  end

  assign o_wb_ready = w_wb_ready;
  assign o_wb_count = r_count;
  assign o_host_gnt = r_host_gnt;
  assign o_rf_we    = r_rf_we;
  assign o_rf_waddr = r_rf_waddr;
  assign o_rf_wdata = r_rf_wdata;
  assign o_sr1_busy = w_sr1_busy;
  assign o_sr2_busy = w_sr2_busy;
endmodule

// File: tb/tb_lc3_wb_scheduler.sv
// Scoreboard bench for lc3_wb_scheduler: queue-based reference model, directed
// scenarios followed by randomized pipeline/host/flush traffic.
module tb_lc3_wb_scheduler;
  localparam int DEPTH = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en = 0, flush = 0, host_req = 0;
  logic [1:0]  ctl = 0;
  logic [15:0] alu = 0, mem = 0, pc = 0, npc = 0, host_data = 0;
  logic [2:0]  dr = 0, host_dr = 0, sr1 = 0, sr2 = 0;
  logic        o_wb_ready, o_host_gnt, o_sr1_busy, o_sr2_busy, o_rf_we;
  logic [2:0]  o_rf_waddr;
  logic [15:0] o_rf_wdata;
  logic [2:0]  o_wb_count;

  lc3_wb_scheduler #(.DEPTH(DEPTH)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable_writeback(en), .i_W_Control_in(ctl),
    .i_aluout(alu), .i_memout(mem), .i_pcout(pc), .i_npc_in(npc), .i_dr(dr),
    .o_wb_ready(o_wb_ready), .i_flush(flush), .i_host_req(host_req), .i_host_dr(host_dr),
    .i_host_data(host_data), .o_host_gnt(o_host_gnt), .i_sr1(sr1), .i_sr2(sr2),
    .o_sr1_busy(o_sr1_busy), .o_sr2_busy(o_sr2_busy), .o_rf_we(o_rf_we),
    .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata), .o_wb_count(o_wb_count));

  typedef struct packed {logic [1:0] c; logic [2:0] d; logic [15:0] a, m, p, n;} wb_t;
  typedef struct packed {logic [2:0] d; logic [15:0] data; logic host;} wr_t;

  wb_t pq[$];          // pending pipeline pushes
  wr_t hq[$];          // pending host requests
  wr_t mq[$];          // model write queue
  wr_t exp_q[$];       // scoreboard: expected rf writes in order
  logic        m_we = 0, m_gnt = 0, m_last_host = 1;
  logic [2:0]  m_waddr = 0;
  logic [15:0] m_wdata = 0;
  int n_chk = 0, n_pass = 0;
  bit saw_full = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [15:0] pick(wb_t x);
    case (x.c)
      2'd0: return x.a;
      2'd1: return x.m;
      2'd2: return x.p;
      default: return x.n;
    endcase
  endfunction

  function automatic bit busy_of(logic [2:0] sr);
    if (m_we && m_waddr == sr) return 1'b1;
    foreach (mq[i]) if (mq[i].d == sr) return 1'b1;
    return 1'b0;
  endfunction

  function automatic wb_t rand_wb();
    wb_t x;
    x.c = 2'($urandom); x.d = 3'($urandom);
    x.a = 16'($urandom); x.m = 16'($urandom); x.p = 16'($urandom); x.n = 16'($urandom);
    return x;
  endfunction

  // Reference model: one write port, queue in order, host alternates on ties.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete(); exp_q.delete();
        m_we = 0; m_gnt = 0; m_last_host = 1; m_waddr = 0; m_wdata = 0;
      end else begin
        bit q_wants, h_wants, q_wins, h_wins, room;
        wr_t w;
        room    = mq.size() < DEPTH;
        q_wants = mq.size() > 0 && !flush;
        h_wants = host_req && !m_gnt;
        if (q_wants && h_wants) q_wins = m_last_host;  // host had the last slot
        else                    q_wins = q_wants;
        h_wins = h_wants && !q_wins;
        if (q_wins) begin
          w = mq.pop_front(); w.host = 0;
          exp_q.push_back(w);
          m_waddr = w.d; m_wdata = w.data; m_last_host = 0;
        end else if (h_wins) begin
          w.d = host_dr; w.data = host_data; w.host = 1;
          exp_q.push_back(w);
          m_waddr = w.d; m_wdata = w.data; m_last_host = 1;
        end
        m_we  = q_wins || h_wins;
        m_gnt = h_wins;
        if (flush) mq.delete();
        else if (en && room) begin
          wb_t x;
          x = '{c: ctl, d: dr, a: alu, m: mem, p: pc, n: npc};
          w.d = dr; w.data = pick(x); w.host = 0;
          mq.push_back(w);
        end
      end
    end
  end

  // Monitor: compares DUT state against the model and drains the scoreboard.
  initial begin
    forever begin
      @(negedge clk); #1;
      if (rst_n) begin
        assert (!(en && !o_wb_ready)) else $error("FAIL protocol: enable_writeback while wb_ready low");
        chk("rf_we", 32'(o_rf_we), 32'(m_we));
        chk("rf_waddr", 32'(o_rf_waddr), 32'(m_waddr));
        chk("rf_wdata", 32'(o_rf_wdata), 32'(m_wdata));
        chk("host_gnt", 32'(o_host_gnt), 32'(m_gnt));
        chk("wb_count", 32'(o_wb_count), 32'(mq.size()));
        chk("wb_ready", 32'(o_wb_ready), 32'(mq.size() < DEPTH));
        chk("sr1_busy", 32'(o_sr1_busy), 32'(busy_of(sr1)));
        chk("sr2_busy", 32'(o_sr2_busy), 32'(busy_of(sr2)));
        if (o_wb_count == 3'(DEPTH) && !o_wb_ready) saw_full = 1;
        if (o_rf_we) begin
          if (exp_q.size() == 0) chk("sb_unexpected_write", 32'(1), 32'(0));
          else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("sb_addr", 32'(o_rf_waddr), 32'(e.d));
            chk("sb_data", 32'(o_rf_wdata), 32'(e.data));
            chk("sb_src_host", 32'(o_host_gnt), 32'(e.host));
          end
        end
      end
    end
  end

  task automatic step();
    wb_t w;
    @(negedge clk);
    if (host_req && o_host_gnt && hq.size() > 0) void'(hq.pop_front());
    host_req = hq.size() > 0;
    if (hq.size() > 0) begin host_dr = hq[0].d; host_data = hq[0].data; end
    if (pq.size() > 0 && o_wb_ready) begin
      w = pq.pop_front();
      en = 1; ctl = w.c; dr = w.d; alu = w.a; mem = w.m; pc = w.p; npc = w.n;
    end else en = 0;
  endtask

  task automatic load(int np, int nh);
    wr_t h;
    for (int i = 0; i < np; i++) pq.push_back(rand_wb());
    for (int i = 0; i < nh; i++) begin
      h.d = 3'($urandom); h.data = 16'($urandom); h.host = 1; hq.push_back(h);
    end
  endtask

  task automatic drain(string nm);
    int b;
    b = 0;
    while ((pq.size() > 0 || hq.size() > 0 || o_wb_count != 0 || host_req) && b < 200) begin
      step(); b++;
    end
    chk({nm, "_drain_bound"}, 32'(b < 200), 32'(1));
    repeat (3) step();
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, "_rf_we"}, 32'(o_rf_we), 32'(0));
    chk({nm, "_rf_waddr"}, 32'(o_rf_waddr), 32'(0));
    chk({nm, "_rf_wdata"}, 32'(o_rf_wdata), 32'(0));
    chk({nm, "_host_gnt"}, 32'(o_host_gnt), 32'(0));
    chk({nm, "_wb_count"}, 32'(o_wb_count), 32'(0));
    chk({nm, "_wb_ready"}, 32'(o_wb_ready), 32'(1));
    chk({nm, "_sr1_busy"}, 32'(o_sr1_busy), 32'(0));
    chk({nm, "_sr2_busy"}, 32'(o_sr2_busy), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    sr1 = 3'd5; sr2 = 3'd2;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1;

    // Single write: memout selected, dr=5.
    pq.push_back('{c: 2'd1, d: 3'd5, a: 16'h1111, m: 16'h1234, p: 16'h2222, n: 16'h3333});
    step();
    step(); chk("t1_busy_after_e1", 32'(o_sr1_busy), 32'(1));
    step();
    chk("t1_rf_we", 32'(o_rf_we), 32'(1));
    chk("t1_rf_waddr", 32'(o_rf_waddr), 32'(5));
    chk("t1_rf_wdata", 32'(o_rf_wdata), 32'h1234);
    chk("t1_busy_after_e2", 32'(o_sr1_busy), 32'(1));
    step(); chk("t1_busy_after_e3", 32'(o_sr1_busy), 32'(0));
    chk("t1_rf_we_off", 32'(o_rf_we), 32'(0));

    // Mux select, four back-to-back writes.
    for (int i = 0; i < 4; i++)
      pq.push_back('{c: 2'(i), d: 3'(i + 1), a: 16'hA000, m: 16'hB000, p: 16'hC000, n: 16'hD000});
    drain("mux");

    // Fill against a continuously requesting host.
    saw_full = 0;
    load(8, 8);
    drain("fill");
    chk("fill_full_seen", 32'(saw_full), 32'(1));

    // Flush coinciding with a push while three entries are queued.
    load(8, 10);
    b = 0;
    while (b < 50) begin
      step(); b++;
      if (o_wb_count == 3'd3 && en) break;
    end
    chk("flush_reach3", 32'(b < 50), 32'(1));
    flush = 1;
    pq.delete();
    step(); flush = 0;
    chk("flush_count0", 32'(o_wb_count), 32'(0));
    drain("flush");

    // Async reset while three entries are waiting.
    load(8, 10);
    b = 0;
    while (b < 50) begin
      step(); b++;
      if (o_wb_count == 3'd3) break;
    end
    chk("rst_reach3", 32'(b < 50), 32'(1));
    pq.delete(); hq.delete(); en = 0; host_req = 0;
    #2 rst_n = 0;
    #1 chk_reset_vals("midrst");
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    repeat (4) step();

    // Tie straight after reset: queue goes first, host next.
    pq.push_back('{c: 2'd0, d: 3'd3, a: 16'h0BAD, m: 16'h0, p: 16'h0, n: 16'h0});
    step();
    begin
      wr_t h;
      h.d = 3'd6; h.data = 16'h600D; h.host = 1; hq.push_back(h);
    end
    step();
    step();
    chk("tie_q_we", 32'(o_rf_we), 32'(1));
    chk("tie_q_not_host", 32'(o_host_gnt), 32'(0));
    chk("tie_q_addr", 32'(o_rf_waddr), 32'(3));
    step();
    chk("tie_h_gnt", 32'(o_host_gnt), 32'(1));
    chk("tie_h_addr", 32'(o_rf_waddr), 32'(6));
    chk("tie_h_data", 32'(o_rf_wdata), 32'h600D);
    drain("tie");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if (pq.size() < 2 && ($urandom % 3) != 0) pq.push_back(rand_wb());
      if (hq.size() == 0 && ($urandom % 4) == 0) load(0, 1);
      step();
      flush = (($urandom % 25) == 0);
      sr1 = 3'($urandom); sr2 = 3'($urandom);
    end
    flush = 0;
    drain("rand");
    #2 chk("sb_empty", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
